// File: rtl/cp0_regs.sv
// MIPS CP0 register subset: BadVAddr, Count, Compare, Status, Cause, EPC.
// MTC0 writes arrive from WB; exception/ERET commits come from the exception
// controller. All outputs except rdata are straight register outputs.
module cp0_regs #(
    parameter int TIMER_IRQ = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  hardware_int_in,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic        is_exception,
    input  logic        is_bd,
    input  logic [4:0]  excep_code,
    input  logic [31:0] excep_pc,
    input  logic        we_badvaddr,
    input  logic [31:0] badvaddr_in,
    input  logic        is_eret,
    output logic        is_ie,
    output logic        is_exl,
    output logic [7:0]  int_mask,
    output logic [5:0]  hardware_int,
    output logic [1:0]  soft_int,
    output logic [31:0] epc_out,
    output logic        timer_int
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic timer_en = (TIMER_IRQ != 0);

    logic [31:0] badvaddr;
    logic [31:0] count;
    logic        count_tick;
    logic [31:0] compare;
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic        cause_ti;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exc_code;
    logic [31:0] epc;

    logic wr_count;
    logic wr_compare;
    logic wr_status;
    logic wr_cause;
    logic wr_epc;
    logic compare_hit;

    assign wr_count    = we && (waddr == REG_COUNT);
    assign wr_compare  = we && (waddr == REG_COMPARE);
    assign wr_status   = we && (waddr == REG_STATUS);
    assign wr_cause    = we && (waddr == REG_CAUSE);
    assign wr_epc      = we && (waddr == REG_EPC);
    assign compare_hit = (count == compare) && (compare != 32'd0);

    // Count advances on every other edge; an MTC0 write replaces the increment
    // but leaves the tick phase running.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count      <= 32'd0;
            count_tick <= 1'b0;
        end else begin
            count_tick <= ~count_tick;
            if (wr_count)
                count <= wdata;
            else if (count_tick)
                count <= count + 32'd1;
        end
    end

    // Compare register and the sticky timer-interrupt flag; a Compare write
    // always wins over a match in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            compare  <= 32'd0;
            cause_ti <= 1'b0;
        end else begin
            if (wr_compare) begin
                compare  <= wdata;
                cause_ti <= 1'b0;
            end else if (compare_hit) begin
                cause_ti <= 1'b1;
            end
        end
    end

    // Status: exception sets EXL, ERET clears it, MTC0 only when neither fires.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_im  <= 8'd0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else begin
            if (wr_status) begin
                status_im <= wdata[15:8];
                status_ie <= wdata[0];
            end
            if (is_exception)
                status_exl <= 1'b1;
            else if (is_eret)
                status_exl <= 1'b0;
            else if (wr_status)
                status_exl <= wdata[1];
        end
    end

    // Cause: IP[7:2] sampled every cycle, IP[1:0] by MTC0, BD/ExcCode on exceptions.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cause_ip_hw    <= 6'd0;
            cause_ip_sw    <= 2'd0;
            cause_bd       <= 1'b0;
            cause_exc_code <= 5'd0;
        end else begin
            cause_ip_hw <= {hardware_int_in[5] | (timer_en & cause_ti), hardware_int_in[4:0]};
            if (wr_cause)
                cause_ip_sw <= wdata[9:8];
            if (is_exception) begin
                cause_exc_code <= excep_code;
                if (!status_exl)
                    cause_bd <= is_bd;
            end
        end
    end

    // EPC: only the first exception (EXL clear) records the restart PC; a
    // delay-slot fault restarts at the branch, one word back.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            epc <= 32'd0;
        end else begin
            if (is_exception) begin
                if (!status_exl)
                    epc <= is_bd ? (excep_pc - 32'd4) : excep_pc;
            end else if (wr_epc) begin
                epc <= wdata;
            end
        end
    end

    // BadVAddr is loaded only by the exception path, never by MTC0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            badvaddr <= 32'd0;
        else if (is_exception && we_badvaddr)
            badvaddr <= badvaddr_in;
    end

    // MFC0 read mux; BEV reads as constant 1, unimplemented bits/registers read 0.
    always_comb begin
        rdata = 32'd0;
        case (raddr)
            REG_BADVADDR: rdata = badvaddr;
            REG_COUNT:    rdata = count;
            REG_COMPARE:  rdata = compare;
            REG_STATUS:   rdata = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
            REG_CAUSE:    rdata = {cause_bd, cause_ti, 14'd0, cause_ip_hw, cause_ip_sw,
                                   1'b0, cause_exc_code, 2'd0};
            REG_EPC:      rdata = epc;
            default:      rdata = 32'd0;
        endcase
    end

    assign is_ie        = status_ie;
    assign is_exl       = status_exl;
    assign int_mask     = status_im;
    assign hardware_int = cause_ip_hw;
    assign soft_int     = cause_ip_sw;
    assign epc_out      = epc;
    assign timer_int    = cause_ti;

endmodule

// File: doc/cp0_regs.md
CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 The module SHALL have parameter TIMER_IRQ, default 1; when 1, Cause.TI is ORed into IP[7], and when 0, IP[7] is driven by hardware_int_in[5] only.
REQ-002 The module SHALL provide the following ports, one per line (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous reset, active low
- hardware_int_in  in  6  external interrupt lines, level sensitive
- we  in  1  MTC0 write strobe, from the WB stage
- waddr  in  5  MTC0 target register number
- wdata  in  32  MTC0 data
- raddr  in  5  MFC0 source register number
- rdata  out  32  MFC0 read data, combinational
- is_exception  in  1  exception commit, from the exception controller
- is_bd  in  1  faulting instruction is in a delay slot
- excep_code  in  5  ExcCode to record
- excep_pc  in  32  PC of the faulting instruction
- we_badvaddr  in  1  BadVAddr update enable
- badvaddr_in  in  32  BadVAddr value
- is_eret  in  1  ERET commit
- is_ie  out  1  Status.IE
- is_exl  out  1  Status.EXL
- int_mask  out  8  Status.IM[7:0], bits 15:8
- hardware_int  out  6  Cause.IP[7:2]
- soft_int  out  2  Cause.IP[1:0]
- epc_out  out  32  EPC, used as the ERET target
- timer_int  out  1  Cause.TI

Function
REQ-003 The block SHALL implement registers BadVAddr (8), Count (9), Compare (11), Status (12), Cause (13) and EPC (14).
REQ-004 Writable bits SHALL be: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; Count, Compare and EPC all 32 bits; BadVAddr is not writable by MTC0.
REQ-005 Every unimplemented bit SHALL read 0, except Status.BEV[22], which SHALL read as a constant 1.
REQ-006 rdata SHALL return the register selected by raddr combinationally, and SHALL return 0 for unimplemented register numbers.
REQ-007 Count SHALL increment by 1 on every second clock edge using an internal toggle bit, and SHALL wrap from 0xFFFF_FFFF to 0.
REQ-008 An MTC0 write to Count SHALL override that cycle's increment, and SHALL not reset the toggle bit.
REQ-009 Cause.TI SHALL be set on the cycle after Count equals Compare, when Compare is nonzero, and SHALL hold until an MTC0 write to Compare.
REQ-010 A Compare write in the same cycle as a match SHALL leave TI cleared.
REQ-011 Cause.IP[7:2] SHALL be registered every cycle from hardware_int_in, with TI ORed into IP[7] when TIMER_IRQ=1; this gives one cycle of latency to the hardware_int output.
REQ-012 On is_exception=1 with EXL=0, the block SHALL set EPC to excep_pc-4 if is_bd=1, else to excep_pc, and SHALL set Cause.BD to is_bd.
REQ-013 On is_exception=1 with EXL already 1, EPC and Cause.BD SHALL be left unchanged.
REQ-014 On every is_exception=1, the block SHALL set Status.EXL to 1 and Cause.ExcCode[6:2] to excep_code.
REQ-015 On is_exception=1 with we_badvaddr=1, BadVAddr SHALL be loaded from badvaddr_in; otherwise BadVAddr SHALL hold.
REQ-016 On is_eret=1, Status.EXL SHALL be cleared.
REQ-017 Same-cycle priority SHALL be is_exception over is_eret over an MTC0 write, for any conflicting field (EXL, EPC).
- An MTC0 write to a non-conflicting field in that cycle still takes effect.
REQ-018 All outputs other than rdata SHALL be direct register outputs with no combinational input-to-output path.
REQ-019 New values SHALL become visible on outputs the cycle after the write; the block SHALL not provide write-to-read bypass.
REQ-020 EPC arithmetic SHALL be 32-bit modulo; an excep_pc of 0 with is_bd=1 SHALL give 0xFFFF_FFFC.

Reset
REQ-021 While resetn=0, asynchronously, Status SHALL read 0x0040_0000, and Cause, EPC, BadVAddr, Count, Compare and the toggle bit SHALL read 0.
REQ-022 Consequently is_ie=0, is_exl=0, int_mask=0, hardware_int=0, soft_int=0, epc_out=0 and timer_int=0 during reset.
REQ-023 A reset asserted mid-operation, including during an exception commit cycle, SHALL discard all pending updates.
REQ-024 After resetn rises, the first Count increment SHALL occur on the second rising edge.

Verification
REQ-025 MTC0 Status=0x0000_FF03 -> the next cycle gives is_ie=1, is_exl=1, int_mask=0xFF, and rdata(12)=0x0040_FF03.
REQ-026 is_exception with code 0x04, excep_pc=0xBFC0_0100, is_bd=1, we_badvaddr=1, badvaddr_in=0x0000_0003 -> EPC=0xBFC0_00FC, Cause=0x8000_0010, BadVAddr=0x3, EXL=1.
REQ-027 A second exception while EXL=1, with excep_pc=0x8000_0000 -> EPC is unchanged and ExcCode is updated.
REQ-028 is_eret together with is_exception in the same cycle -> EXL=1; is_eret alone on the next cycle -> EXL=0.
REQ-029 Compare=10, Count=0 -> TI=1 and hardware_int[5]=1 twenty-two cycles later; an MTC0 write to Compare -> TI=0 on the next cycle.
REQ-030 Assert resetn=0 while Count=0x1234 -> all registers read their reset values immediately, without waiting for a clock edge.
